// File: rtl/flash_page_selftest.sv
// rtl/flash_page_selftest.sv - single-page erase / program / verify self-test sequencer
//
// Drives the flash controller request/handshake ports through one self-test:
// WREN, sector-0 erase, WREN, page-0 program with a generated pattern, then
// read-back with a byte compare. Reports pass/fail, error count and first
// failing offset.
//
// Ports
//   sys_clk, rst          clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only when idle
//   busy, done            test in progress / one-cycle completion pulse
//   pass, timeout         result of the last test, watchdog abort flag
//   err_cnt, first_err    mismatch count (saturating) / first mismatch offset
//   disp_data             {A|E, 3'b0, err_cnt, first_err} for the segment display
//   wren_req/wren_end     write-enable handshake
//   erase_req/erase_end   sector-erase handshake
//   write_req/write_ack/write_end, write_data   page-program handshake
//   read_req/read_ack/read_end, read_data       page-read handshake
//
// Build option: define PATTERN_LFSR_EN for an 8-bit LFSR pattern
// (x^8+x^6+x^5+x^4+1); otherwise the pattern is SEED + n.

module flash_page_selftest #(
  parameter int unsigned  PAGE_SIZE      = 256,
  parameter logic [7:0]   SEED           = 8'hBC,
  parameter logic [23:0]  TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_cnt,
  output logic [7:0]  first_err,
  output logic        timeout,
  output logic [23:0] disp_data,
  output logic        wren_req,
  input  logic        wren_end,
  output logic        erase_req,
  input  logic        erase_end,
  output logic        write_req,
  input  logic        write_ack,
  input  logic        write_end,
  output logic [7:0]  write_data,
  output logic        read_req,
  input  logic        read_ack,
  input  logic        read_end,
  input  logic [7:0]  read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN1, S_ERASE, S_WREN2, S_WRITE, S_READ, S_FINISH
  } state_t;

  localparam logic [8:0] PAGE_LEN = 9'(PAGE_SIZE);

`ifdef PATTERN_LFSR_EN
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0] SEED_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
`else
  localparam logic [7:0] SEED_INIT = SEED;
`endif

  function automatic logic [7:0] pat_next(input logic [7:0] p);
`ifdef PATTERN_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  state_t      state, state_nxt;
  logic [23:0] wd_cnt;
  logic [8:0]  w_idx, r_idx;
  logic [7:0]  r_pat;
  logic        short_wr;
  logic        req_any, wd_hit, end_hit, abort;
  logic        wren_nxt, erase_nxt, write_nxt, read_nxt;
  logic        wr_take, rd_take, mismatch;

  assign req_any  = wren_req | erase_req | write_req | read_req;
  // Fires on the last allowed cycle so a request is high for exactly TIMEOUT_CYCLES.
  assign wd_hit   = req_any && ((wd_cnt + 24'd1) == TIMEOUT_CYCLES);
  assign wr_take  = (state == S_WRITE) && write_ack && (w_idx < PAGE_LEN);
  assign rd_take  = (state == S_READ) && read_ack && (r_idx < PAGE_LEN);
  assign mismatch = rd_take && (read_data != r_pat);

  assign disp_data = {(pass ? 4'hA : 4'hE), 3'b000, err_cnt, first_err};

  // State register and registered requests
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wren_req  <= 1'b0;
      erase_req <= 1'b0;
      write_req <= 1'b0;
      read_req  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wren_req  <= wren_nxt;
      erase_req <= erase_nxt;
      write_req <= write_nxt;
      read_req  <= read_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    end_hit   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WREN1;
      S_WREN1:  if (wren_end) begin state_nxt = S_ERASE;  end_hit = 1'b1; end
      S_ERASE:  if (erase_end) begin state_nxt = S_WREN2; end_hit = 1'b1; end
      S_WREN2:  if (wren_end) begin state_nxt = S_WRITE;  end_hit = 1'b1; end
      S_WRITE:  if (write_end) begin state_nxt = S_READ;  end_hit = 1'b1; end
      S_READ:   if (read_end) begin state_nxt = S_FINISH; end_hit = 1'b1; end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // A handshake completing on the watchdog's last cycle still counts.
    if (wd_hit && !end_hit) begin
      abort     = 1'b1;
      state_nxt = S_FINISH;
    end
  end

  // Output decode: requests follow the state being entered
  always_comb begin
    wren_nxt  = (state_nxt == S_WREN1) || (state_nxt == S_WREN2);
    erase_nxt = (state_nxt == S_ERASE);
    write_nxt = (state_nxt == S_WRITE);
    read_nxt  = (state_nxt == S_READ);
    busy      = (state != S_IDLE);
  end

  // Datapath: watchdog, pattern generators, compare and result
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wd_cnt     <= '0;
      w_idx      <= '0;
      r_idx      <= '0;
      write_data <= SEED_INIT;
      r_pat      <= SEED_INIT;
      err_cnt    <= '0;
      first_err  <= 8'hFF;
      short_wr   <= 1'b0;
      timeout    <= 1'b0;
      pass       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == S_FINISH);

      if (state_nxt != state) wd_cnt <= '0;
      else if (req_any)       wd_cnt <= wd_cnt + 24'd1;

      if ((state == S_IDLE) && start) begin
        w_idx      <= '0;
        r_idx      <= '0;
        write_data <= SEED_INIT;
        r_pat      <= SEED_INIT;
        err_cnt    <= '0;
        first_err  <= 8'hFF;
        short_wr   <= 1'b0;
        timeout    <= 1'b0;
        pass       <= 1'b0;
      end

      if (wr_take) begin
        w_idx      <= w_idx + 9'd1;
        write_data <= pat_next(write_data);
      end

      // Include an ack arriving together with write_end in the byte count.
      if ((state == S_WRITE) && write_end)
        short_wr <= ((w_idx + 9'(wr_take)) != PAGE_LEN);

      if (rd_take) begin
        r_idx <= r_idx + 9'd1;
        r_pat <= pat_next(r_pat);
        if (mismatch) begin
          if (err_cnt != 9'd256) err_cnt <= err_cnt + 9'd1;
          if (err_cnt == 9'd0)   first_err <= r_idx[7:0];
        end
      end

      if (abort) timeout <= 1'b1;

      if (state == S_FINISH)
        pass <= (err_cnt == 9'd0) && (r_idx == PAGE_LEN) && !short_wr && !timeout;
    end
  end

endmodule

// File: doc/flash_page_selftest.md
# flash_page_selftest

Sequencer that sits directly upstream of `flash_contorl`. On a start pulse it drives the controller's request/handshake ports through a full single-page self-test:

- erase sector 0
- write-enable, then program page 0 with a generated byte pattern
- read the page back and compare every byte

It reports pass/fail, error count and first failing offset. The result bus feeds the segment display in place of the raw flash ID.

## Interface

Parameters
- `PAGE_SIZE`, default 256: bytes programmed/read. Legal range 1..256.
- `SEED`, default 8'hBC: first pattern byte.
- `TIMEOUT_CYCLES`, default 24'd5_000_000: maximum `sys_clk` cycles any single controller request may stay high.

Ports
- `sys_clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a test when idle.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse when the test finishes.
- `pass` out 1: result of the last test, held until the next accepted start.
- `err_cnt` out 9: mismatching bytes in the last test. Saturates at 256.
- `first_err` out 8: byte offset of the first mismatch; 8'hFF if none.
- `timeout` out 1: last test aborted by the watchdog.
- `disp_data` out 24: `{4'hA or 4'hE, 3'b0, err_cnt, first_err}`. 4'hA = pass, 4'hE = fail.
- `wren_req` out 1 / `wren_end` in 1: write-enable handshake.
- `erase_req` out 1 / `erase_end` in 1: sector-erase handshake. Address is tied 0 in top.
- `write_req` out 1 / `write_ack` in 1 / `write_end` in 1: page-program handshake.
- `write_data` out 8: byte to program.
- `read_req` out 1 / `read_ack` in 1 / `read_end` in 1: read handshake.
- `read_data` in 8: byte to compare.

## Operation

- States: IDLE → WREN1 → ERASE → WREN2 → WRITE → READ → FINISH → IDLE.
- Every `*_req` is registered. It is high exactly while in its state:
  - `wren_req` in WREN1 and WREN2.
  - `erase_req` in ERASE.
  - `write_req` in WRITE.
  - `read_req` in READ.
- Leaving a state requires that state's `*_end` pulse.
- IDLE: `start` latches a new test. On entry the block clears `err_cnt`, `w_idx`, `r_idx` and `timeout`, sets `first_err` = 8'hFF, and loads the pattern generator with `SEED`. It then goes to WREN1.
- WRITE: `write_data` = pattern(`w_idx`). Each `write_ack` advances `w_idx` and the generator by one. Acks beyond `PAGE_SIZE` are ignored.
- On `write_end`, if `w_idx` != `PAGE_SIZE` the test is marked failed (short write). Either way the block proceeds to READ.
- READ: each `read_ack` compares `read_data` with pattern(`r_idx`) from a second generator instance, then increments `r_idx`.
  - On a mismatch, `err_cnt` increments (saturating).
  - On the first mismatch, `first_err` is set to `r_idx[7:0]`.
  - Acks beyond `PAGE_SIZE` are ignored.
- `read_end` → FINISH.
- FINISH:
  - `pass` = (`err_cnt`==0) && (`r_idx`==`PAGE_SIZE`) && no short write && !`timeout`.
  - `done` pulses; next state is IDLE.
- Watchdog: a 24-bit counter clears on every state change and increments while any `*_req` is high. On reaching `TIMEOUT_CYCLES` the block sets `timeout`, drops all requests and jumps to FINISH, where `pass` = 0.
- An `*_end` pulse that does not match the current state is ignored.
- `start` while `busy` is ignored.
- Pattern, default: pattern(n) = `SEED` + n, mod 256.

## Timing

- Reset values:
  - all `*_req`, `busy`, `done`, `pass`, `timeout` = 0
  - `err_cnt` = 0, `first_err` = 8'hFF, `write_data` = `SEED`
  - `disp_data` = 24'hE000FF
  - state IDLE
- `start` at cycle t → `busy` and `wren_req` high at t+1.
- `*_end` at cycle t → current req low at t+1. The next state's req is high at t+1 (back-to-back, no gap).
- `write_data` updates at t+1 after `write_ack` at t, so it is valid before the controller's next byte fetch.
- Compare is registered: `read_ack` at t → `err_cnt`/`first_err` updated at t+1.
- `read_end` at t → FINISH at t+1 → `done`, `pass` and `disp_data` valid at t+2. `busy` falls at t+2.
- `read_ack` and `read_end` in the same cycle: the byte is compared before the result is evaluated.
- Reset mid-test: all requests drop asynchronously and the test is not resumed. The controller must tolerate an abandoned request.

## Configuration

- `PATTERN_LFSR_EN` defined: both generators are 8-bit Fibonacci LFSRs, x^8+x^6+x^5+x^4+1, seeded with `SEED`. A `SEED` of 0 is forced to 8'h01.
- `PATTERN_LFSR_EN` undefined: incrementing pattern `SEED`+n. No LFSR logic is synthesized.

## Test plan

- Ideal controller model, `PAGE_SIZE`=256, `SEED`=8'hBC, incrementing pattern. The model echoes written bytes → request order WREN, ERASE, WREN, WRITE, READ; 256 write_acks with data BC,BD,…,BB; `pass`=1, `err_cnt`=0, `first_err`=FF, `disp_data`=24'hA000FF.
- Model corrupts bytes at offsets 5 and 200 on read → `pass`=0, `err_cnt`=2, `first_err`=8'h05, `disp_data`=24'hE00205.
- Model never returns `erase_end`, with `TIMEOUT_CYCLES`=1000 → `erase_req` drops 1000 cycles after rising; `timeout`=1, `done` pulses, `pass`=0.
- Model issues `write_end` after 255 acks → `pass`=0 even with a clean read-back. Also pulse `start` during WRITE → ignored, with one `done` only.
- Deassert `rst` mid-READ, then restart → all requests low immediately; the second test passes with fresh counters.
- With `PATTERN_LFSR_EN` defined, `SEED`=8'h00 → first `write_data`=8'h01, and the sequence follows the LFSR; the echo test passes.
